// File: rtl/multi_design_mux.sv
// N-way IO pad mux: routes one design to the Caravel pads, with a drain interval on every switch.
// Optional MUX_SEL_LOCK_EN adds sel_lock/lock_drop to ignore strobes while a design is active.
module multi_design_mux #(
  parameter int unsigned N_DESIGNS    = 4,
  parameter int unsigned SEL_W        = 4,
  parameter int unsigned IO_W         = 38,
  parameter int unsigned GUARD_CYCLES = 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n,
  input  logic [SEL_W-1:0]          sel_id,
  input  logic                      sel_clk,
`ifdef MUX_SEL_LOCK_EN
  input  logic                      sel_lock,
  output logic                      lock_drop,
`endif
  input  logic [IO_W-1:0]           io_in,
  output logic [IO_W-1:0]           io_out,
  output logic [IO_W-1:0]           io_oeb,
  input  logic [N_DESIGNS*IO_W-1:0] dsn_out,
  input  logic [N_DESIGNS*IO_W-1:0] dsn_oeb,
  output logic [N_DESIGNS*IO_W-1:0] dsn_io_in,
  output logic [N_DESIGNS-1:0]      dsn_rst_n,
  output logic [SEL_W-1:0]          active_id,
  output logic                      active_valid,
  output logic                      busy
);

  localparam int unsigned CNT_W = $clog2(GUARD_CYCLES);

  localparam logic [1:0] ST_NONE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic [1:0]                state, state_nx;
  logic [CNT_W-1:0]          cnt, cnt_nx;
  logic [SEL_W-1:0]          req_id, req_nx, id_nx;
  logic                      sync1, sync2, sync3;
  logic                      strobe, locked, take, route;
  logic [IO_W-1:0]           sel_out, sel_oeb;
  logic [N_DESIGNS*IO_W-1:0] io_fan;

  assign strobe = sync2 & ~sync3;

`ifdef MUX_SEL_LOCK_EN
  assign locked = sel_lock && (state == ST_ACTIVE);
`else
  assign locked = 1'b0;
`endif

  assign take = strobe & ~locked;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    req_nx   = req_id;
    id_nx    = active_id;
    if (take) begin
      state_nx = ST_DRAIN;
      cnt_nx   = CNT_W'(GUARD_CYCLES - 1);
      req_nx   = sel_id;
    end else if (state == ST_DRAIN) begin
      if (cnt == '0) begin
        if (req_id < SEL_W'(N_DESIGNS)) begin
          state_nx = ST_ACTIVE;
          id_nx    = req_id;
        end else begin
          state_nx = ST_NONE;
          id_nx    = '0;
        end
      end else begin
        cnt_nx = cnt - 1'b1;
      end
    end
  end

  // Route only when ACTIVE now and staying ACTIVE: pads go safe on the first DRAIN
  // cycle and the first routed value lands one cycle after ACTIVE is entered.
  assign route = (state == ST_ACTIVE) && (state_nx == ST_ACTIVE);

  always_comb begin
    sel_out   = '0;
    sel_oeb   = '1;
    io_fan    = '0;
    dsn_rst_n = '0;
    for (int unsigned k = 0; k < N_DESIGNS; k++) begin
      if (active_id == SEL_W'(k)) begin
        sel_out                 = dsn_out[k*IO_W +: IO_W];
        sel_oeb                 = dsn_oeb[k*IO_W +: IO_W];
        io_fan[k*IO_W +: IO_W]  = io_in;
        dsn_rst_n[k]            = (state == ST_ACTIVE);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state     <= ST_NONE;
      cnt       <= '0;
      req_id    <= '0;
      active_id <= '0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      io_out    <= '0;
      io_oeb    <= '1;
      dsn_io_in <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      req_id    <= req_nx;
      active_id <= id_nx;
      sync1     <= sel_clk;
      sync2     <= sync1;
      sync3     <= sync2;
      if (route) begin
        io_out    <= sel_out;
        io_oeb    <= sel_oeb;
        dsn_io_in <= io_fan;
      end else begin
        io_out    <= '0;
        io_oeb    <= '1;
        dsn_io_in <= '0;
      end
    end
  end

`ifdef MUX_SEL_LOCK_EN
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) lock_drop <= 1'b0;
    else           lock_drop <= strobe & locked;
  end
`endif

  assign active_valid = (state == ST_ACTIVE);
  assign busy         = (state == ST_DRAIN);

endmodule

// File: tb/tb_multi_design_mux.sv
// Randomised and directed bench for multi_design_mux against a per-cycle behavioural model.
// Define MUX_SEL_LOCK_EN to also exercise the sel_lock/lock_drop feature.
module tb_multi_design_mux;

  localparam int unsigned N  = 4;
  localparam int unsigned SW = 4;
  localparam int unsigned W  = 38;
  localparam int unsigned G  = 8;
  localparam int unsigned TW = N * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sel_clk;
  logic [SW-1:0] sel_id;
  logic [W-1:0]  io_in, io_out, io_oeb;
  logic [TW-1:0] dsn_out, dsn_oeb, dsn_io_in;
  logic [N-1:0]  dsn_rst_n;
  logic [SW-1:0] active_id;
  logic          active_valid, busy;
  logic          sel_lock;
`ifdef MUX_SEL_LOCK_EN
  logic          lock_drop;
`endif

  always #5 clk = ~clk;

  multi_design_mux #(
    .N_DESIGNS(N), .SEL_W(SW), .IO_W(W), .GUARD_CYCLES(G)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_n     (rst_n),
    .sel_id       (sel_id),
    .sel_clk      (sel_clk),
`ifdef MUX_SEL_LOCK_EN
    .sel_lock     (sel_lock),
    .lock_drop    (lock_drop),
`endif
    .io_in        (io_in),
    .io_out       (io_out),
    .io_oeb       (io_oeb),
    .dsn_out      (dsn_out),
    .dsn_oeb      (dsn_oeb),
    .dsn_io_in    (dsn_io_in),
    .dsn_rst_n    (dsn_rst_n),
    .active_id    (active_id),
    .active_valid (active_valid),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: sel_clk history (oldest last), drain cycles remaining, routed flag, ids.
  bit h[3]     = '{0, 0, 0};
  int m_left   = 0;
  bit m_routed = 0;
  int m_id     = 0;
  int m_req    = 0;
  bit rnd_data = 1;

  task automatic check(string tag, logic [TW-1:0] obs, logic [TW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] rnd_bus();
    logic [TW-1:0] r = '0;
    repeat (5) r = (r << 32) | TW'($urandom);
    return r;
  endfunction

  task automatic tick();
    bit            r_c, sc_c, lk_c, strobe, ignore, stay;
    int            sid_c;
    logic [TW-1:0] dout_c, e_in;
    logic [W-1:0]  pin_c, e_out, e_oeb;
    bit            e_drop;
    r_c    = rst_n;
    sc_c   = sel_clk;
    lk_c   = sel_lock;
    sid_c  = int'(sel_id);
    dout_c = dsn_out;
    pin_c  = io_in;
    e_drop = 0;
    @(posedge clk);
    if (!r_c) begin
      h = '{0, 0, 0};
      m_left = 0; m_routed = 0; m_id = 0; m_req = 0;
      e_out = '0; e_oeb = '1; e_in = '0;
    end else begin
      strobe = h[1] && !h[2];
      ignore = strobe && lk_c && m_routed;
      e_drop = ignore;
      stay   = m_routed && !(strobe && !ignore);
      if (stay) begin
        e_out = dout_c[m_id*W +: W];
        e_oeb = dsn_oeb[m_id*W +: W];
        e_in  = TW'(pin_c) << (m_id * W);
      end else begin
        e_out = '0; e_oeb = '1; e_in = '0;
      end
      if (strobe && !ignore) begin
        m_left = G; m_routed = 0; m_req = sid_c;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_routed = (m_req < N);
          m_id     = (m_req < N) ? m_req : 0;
        end
      end
      h[2] = h[1]; h[1] = h[0]; h[0] = sc_c;
    end
    #1;
    check("io_out",       TW'(io_out),       TW'(e_out));
    check("io_oeb",       TW'(io_oeb),       TW'(e_oeb));
    check("dsn_io_in",    dsn_io_in,         e_in);
    check("dsn_rst_n",    TW'(dsn_rst_n),    m_routed ? (TW'(1) << m_id) : '0);
    check("active_id",    TW'(active_id),    TW'(m_id));
    check("active_valid", TW'(active_valid), TW'(m_routed));
    check("busy",         TW'(busy),         TW'(m_left > 0));
`ifdef MUX_SEL_LOCK_EN
    check("lock_drop",    TW'(lock_drop),    TW'(e_drop));
`endif
    if (rnd_data) begin
      dsn_out = rnd_bus();
      dsn_oeb = rnd_bus();
      io_in   = W'(rnd_bus());
    end
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic strobe_to(int id, int hold);
    sel_id = SW'(id);
    ticks(3);
    sel_clk = 1'b1;
    ticks(2);
    sel_clk = 1'b0;
    ticks(hold);
  endtask

  initial begin
    rst_n    = 1'b0;
    sel_clk  = 1'b0;
    sel_id   = '0;
    sel_lock = 1'b0;
    dsn_out  = rnd_bus();
    dsn_oeb  = rnd_bus();
    io_in    = W'(rnd_bus());
    ticks(2);
    rst_n = 1'b1;
    ticks(20);

    // Select design 2 and time the drain.
    sel_id = SW'(2);
    ticks(3);
    sel_clk = 1'b1;
    ticks(2);
    check("busy_before_drain", TW'(busy), '0);
    tick();
    check("busy_first_drain", TW'(busy), TW'(1));
    sel_clk = 1'b0;
    ticks(7);
    check("busy_last_drain", TW'(busy), TW'(1));
    tick();
    check("drain_done_valid", TW'(active_valid), TW'(1));
    check("drain_done_rst", TW'(dsn_rst_n), TW'(4'b0100));
    rnd_data = 0;
    dsn_out  = '0;
    dsn_out[2*W +: W] = 38'h15_5555_5555;
    dsn_oeb  = '0;
    io_in    = 38'h3F_0000_00FF;
    tick();
    check("route_io_out", TW'(io_out), TW'(38'h15_5555_5555));
    check("route_io_oeb", TW'(io_oeb), '0);
    check("route_in_slice2", dsn_io_in, TW'(38'h3F_0000_00FF) << (2 * W));
    ticks(3);
    rnd_data = 1;

    strobe_to(1, 12);
    check("switch_to_1", TW'(active_id), TW'(1));
    strobe_to(9, 12);
    check("invalid_none", TW'(active_valid), '0);
    check("invalid_hiz", TW'(io_oeb), TW'({W{1'b1}}));

    // Second strobe four clocks into a drain toward id 0.
    sel_id = SW'(0);
    ticks(3);
    sel_clk = 1'b1;
    tick();
    sel_clk = 1'b0;
    sel_id  = SW'(3);
    ticks(3);
    sel_clk = 1'b1;
    tick();
    sel_clk = 1'b0;
    ticks(15);
    check("restart_id3", TW'(active_id), TW'(3));

    strobe_to(3, 12);
    check("reselect_same", TW'(dsn_rst_n), TW'(4'b1000));

    // Reset in the middle of a drain, then in the middle of ACTIVE.
    sel_id = SW'(1);
    ticks(3);
    sel_clk = 1'b1;
    ticks(5);
    rst_n = 1'b0;
    tick();
    check("rst_mid_drain", TW'(busy), '0);
    rst_n   = 1'b1;
    sel_clk = 1'b0;
    ticks(14);
    strobe_to(0, 14);
    rst_n = 1'b0;
    tick();
    check("rst_mid_active", TW'(active_valid), '0);
    rst_n = 1'b1;
    ticks(4);

    for (int i = 0; i < 40; i++) begin
      sel_id = SW'($urandom_range(0, 15));
      ticks($urandom_range(0, 4));
      sel_clk = 1'b1;
      ticks($urandom_range(1, 3));
      sel_clk = 1'b0;
      ticks($urandom_range(1, 14));
    end
    ticks(14);

`ifdef MUX_SEL_LOCK_EN
    strobe_to(0, 14);
    sel_lock = 1'b1;
    strobe_to(1, 12);
    check("lock_holds_id", TW'(active_id), '0);
    check("lock_no_busy", TW'(busy), '0);
    sel_lock = 1'b0;
    strobe_to(1, 12);
    check("unlock_switch", TW'(active_id), TW'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
